// File: rtl/udp_rx_payload_buffer.sv
// udp_rx_payload_buffer: filters Ethernet/IPv4/UDP frames and stores accepted UDP payloads in a
// circular buffer, exposing only committed packets as a valid/ready byte stream.
module udp_rx_payload_buffer #(
   parameter logic [47:0] MY_PA    = 48'h16FD2204B161,
   parameter logic [31:0] MY_IP    = 32'hC0A80328,
   parameter logic [15:0] UDP_PORT = 16'h0400,
   parameter int          ADDR_W   = 10
) (
   input  logic        clkRx,
   input  logic        rst_n,
   input  logic        rx_frame,
   input  logic [7:0]  rx_byte,
   input  logic        rx_byte_valid,
   input  logic        rx_crc_ok,
   output logic [7:0]  rd_data,
   output logic        rd_last,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        pkt_committed,
   output logic        pkt_dropped,
   output logic [15:0] drop_count
);
   localparam logic [15:0] MAX_PLEN = 16'((1 << ADDR_W) - 1);
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, SKIP} state_t;
   state_t r_state, w_next;
   logic [10:0] r_idx;
   logic r_frame_d, r_bad, w_bad, w_we, w_chk, w_last, w_full, w_byte, w_end, w_commit, w_fetch, w_len_bad;
   logic [7:0] r_len_hi, w_exp;
   logic [15:0] r_rem, w_len, w_plen;
   logic [ADDR_W-1:0] r_wr_ptr, r_wr_tmp, r_rd_ptr;
   logic [8:0] r_mem [1<<ADDR_W];
   assign w_byte    = rx_frame & rx_byte_valid;
   assign w_end     = r_frame_d & ~rx_frame;
   assign w_len     = {r_len_hi, rx_byte};
   assign w_plen    = w_len - 16'd8;
   assign w_len_bad = (w_len < 16'd9) | (w_plen > MAX_PLEN);
   assign w_last    = r_rem == 16'd1;
   assign w_full    = r_wr_tmp + ADDR_W'(1) == r_rd_ptr;
   assign w_commit  = w_end & (r_state == SKIP) & ~r_bad & rx_crc_ok;
   assign w_fetch   = (r_rd_ptr != r_wr_ptr) & (~rd_valid | rd_ready);
   // Fixed header fields that must match; unlisted offsets are not checked.
   always_comb begin
      w_chk = 1'b1;
      w_exp = 8'h00;
      case (r_idx)
         11'd0:   w_exp = MY_PA[47:40];
         11'd1:   w_exp = MY_PA[39:32];
         11'd2:   w_exp = MY_PA[31:24];
         11'd3:   w_exp = MY_PA[23:16];
         11'd4:   w_exp = MY_PA[15:8];
         11'd5:   w_exp = MY_PA[7:0];
         11'd12:  w_exp = 8'h08;
         11'd13:  w_exp = 8'h00;
         11'd14:  w_exp = 8'h45;
         11'd23:  w_exp = 8'h11;
         11'd30:  w_exp = MY_IP[31:24];
         11'd31:  w_exp = MY_IP[23:16];
         11'd32:  w_exp = MY_IP[15:8];
         11'd33:  w_exp = MY_IP[7:0];
         11'd36:  w_exp = UDP_PORT[15:8];
         11'd37:  w_exp = UDP_PORT[7:0];
         default: w_chk = 1'b0;
      endcase
   end
   always_comb begin
      w_next = r_state;
      w_bad  = r_bad;
      w_we   = 1'b0;
      if (w_byte) begin
         if (r_state == IDLE || r_state == HDR) begin
            w_next = HDR;
            w_bad  = 1'b0;
            if (w_chk && rx_byte != w_exp) begin
               w_next = SKIP;
               w_bad  = 1'b1;
            end else if (r_idx == 11'd39) begin
               w_next = w_len_bad ? SKIP : PAYLOAD;
               w_bad  = w_len_bad;
            end
         end else if (r_state == PAYLOAD && r_idx >= 11'd42) begin
            w_we   = ~w_full;
            w_bad  = w_full;
            w_next = (w_full | w_last) ? SKIP : PAYLOAD;
         end
      end
   end
   always_ff @(posedge clkRx)
      if (w_we) r_mem[r_wr_tmp] <= {w_last, rx_byte};
   always_ff @(posedge clkRx or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_frame_d     <= 1'b0;
         r_bad         <= 1'b0;
         r_len_hi      <= '0;
         r_rem         <= '0;
         r_wr_ptr      <= '0;
         r_wr_tmp      <= '0;
         r_rd_ptr      <= '0;
         rd_data       <= '0;
         rd_last       <= 1'b0;
         rd_valid      <= 1'b0;
         pkt_committed <= 1'b0;
         pkt_dropped   <= 1'b0;
         drop_count    <= '0;
      end else begin
         r_frame_d     <= rx_frame;
         r_idx         <= rx_frame ? r_idx + 11'(rx_byte_valid) : 11'd0;
         pkt_committed <= w_commit;
         pkt_dropped   <= w_end & ~w_commit;
         if (w_byte && r_idx == 11'd38) r_len_hi <= rx_byte;
         if (w_byte && r_idx == 11'd39) r_rem <= w_plen;
         else if (w_we) r_rem <= r_rem - 16'd1;
         if (w_end) begin
            r_state <= IDLE;
            if (w_commit) r_wr_ptr <= r_wr_tmp;
            else begin
               r_wr_tmp <= r_wr_ptr;
               if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
         end else begin
            r_state <= w_next;
            r_bad   <= w_bad;
            if (w_we) r_wr_tmp <= r_wr_tmp + ADDR_W'(1);
         end
         // RAM read lands straight in the output register, refilled whenever it empties or is taken
         rd_valid <= w_fetch | (rd_valid & ~rd_ready);
         if (w_fetch) begin
            {rd_last, rd_data} <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_udp_rx_payload_buffer.sv
// tb_udp_rx_payload_buffer: directed frames into a default-size buffer and a 16-entry buffer,
// checking commit/drop behaviour and the byte stream read back.
module tb_udp_rx_payload_buffer;
   localparam logic [47:0] MY_PA = 48'h16FD2204B161;
   logic clkRx = 1'b0;
   always #5 clkRx = ~clkRx;
   logic rst_n = 1'b0, rx_frame = 1'b0, rx_byte_valid = 1'b0, rx_crc_ok = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic rd_ready = 1'b1, rd_ready4 = 1'b1;
   logic [7:0] rd_data, rd_data4;
   logic rd_last, rd_valid, pkt_committed, pkt_dropped;
   logic rd_last4, rd_valid4, pkt_committed4, pkt_dropped4;
   logic [15:0] drop_count, drop_count4;
   int n_checks = 0, n_fail = 0, n_com = 0, n_drop = 0, n_com4 = 0, n_drop4 = 0;
   logic [8:0] q[$], q4[$];
   logic [7:0] s_data;
   logic s_valid, s_last;
   logic [15:0] s_cnt;
   udp_rx_payload_buffer dut (
      .clkRx(clkRx), .rst_n(rst_n), .rx_frame(rx_frame), .rx_byte(rx_byte),
      .rx_byte_valid(rx_byte_valid), .rx_crc_ok(rx_crc_ok), .rd_data(rd_data), .rd_last(rd_last),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .pkt_committed(pkt_committed),
      .pkt_dropped(pkt_dropped), .drop_count(drop_count));
   udp_rx_payload_buffer #(.ADDR_W(4)) dut4 (
      .clkRx(clkRx), .rst_n(rst_n), .rx_frame(rx_frame), .rx_byte(rx_byte),
      .rx_byte_valid(rx_byte_valid), .rx_crc_ok(rx_crc_ok), .rd_data(rd_data4), .rd_last(rd_last4),
      .rd_valid(rd_valid4), .rd_ready(rd_ready4), .pkt_committed(pkt_committed4),
      .pkt_dropped(pkt_dropped4), .drop_count(drop_count4));
   always @(negedge clkRx) begin
      if (rd_valid && rd_ready) q.push_back({rd_last, rd_data});
      if (rd_valid4 && rd_ready4) q4.push_back({rd_last4, rd_data4});
      if (pkt_committed) n_com++;
      if (pkt_dropped) n_drop++;
      if (pkt_committed4) n_com4++;
      if (pkt_dropped4) n_drop4++;
   end
   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   task automatic tick;
      @(posedge clkRx);
      #1;
   endtask
   task automatic send_frame(input logic [7:0] ip_lo, input int plen, input logic [7:0] start,
                             input logic crc, input int rst_at);
      logic [7:0] f[$];
      logic [15:0] ulen;
      ulen = 16'(plen + 8);
      for (int i = 0; i < 6; i++) f.push_back(8'(MY_PA >> (8 * (5 - i))));
      f = {f, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00, 8'h45, 8'h00};
      f = {f, 8'(16'(plen + 28) >> 8), 8'(plen + 28), 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11};
      f = {f, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h03, 8'h01, 8'hC0, 8'hA8, 8'h03, ip_lo};
      f = {f, 8'h12, 8'h34, 8'h04, 8'h00, ulen[15:8], ulen[7:0], 8'h00, 8'h00};
      for (int i = 0; i < plen; i++) f.push_back(8'(start + 8'(i)));
      while (f.size() < 60) f.push_back(8'h00);
      f = {f, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < f.size(); i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            s_data = rd_data; s_valid = rd_valid; s_last = rd_last; s_cnt = drop_count;
            tick; tick;
            rst_n = 1'b1;
         end
         rx_frame = 1'b1; rx_byte = f[i]; rx_byte_valid = 1'b1;
         tick;
         rx_byte_valid = 1'b0;
         tick;
      end
      rx_frame = 1'b0; rx_crc_ok = crc;
      tick;
      rx_crc_ok = 1'b0;
      repeat (40) tick;
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick;
      n_checks += 6;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      if (rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
      if (pkt_committed !== 1'b0) begin n_fail++; $display("FAIL reset_committed: got %b want 0", pkt_committed); end
      if (pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b want 0", pkt_dropped); end
      if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop_count: got %h want 0", drop_count); end
      rst_n = 1'b1;
      tick;
   endtask
   task automatic test_good;
      int c0;
      logic [8:0] e;
      q.delete(); c0 = n_com;
      send_frame(8'h28, 18, 8'h00, 1'b1, -1);
      n_checks += 3;
      if (n_com - c0 !== 1) begin n_fail++; $display("FAIL good_commit: got %0d want 1", n_com - c0); end
      if (drop_count !== 16'd0) begin n_fail++; $display("FAIL good_drop_count: got %0d want 0", drop_count); end
      if (q.size() !== 18) begin n_fail++; $display("FAIL good_len: got %0d want 18", q.size()); end
      for (int i = 0; i < 18; i++) begin
         e = {i == 17, 8'(i)};
         n_checks++;
         if (q[i] !== e) begin n_fail++; $display("FAIL good_byte%0d: got %h want %h", i, q[i], e); end
      end
   endtask
   task automatic test_bad_ip;
      int d0;
      q.delete(); d0 = n_drop;
      send_frame(8'h29, 18, 8'h00, 1'b1, -1);
      n_checks += 4;
      if (n_drop - d0 !== 1) begin n_fail++; $display("FAIL ip_drop_pulse: got %0d want 1", n_drop - d0); end
      if (drop_count !== 16'd1) begin n_fail++; $display("FAIL ip_drop_count: got %0d want 1", drop_count); end
      if (q.size() !== 0) begin n_fail++; $display("FAIL ip_read: got %0d bytes want 0", q.size()); end
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ip_rd_valid: got %b want 0", rd_valid); end
   endtask
   task automatic test_bad_crc;
      logic [8:0] e;
      q.delete();
      send_frame(8'h28, 8, 8'h50, 1'b0, -1);
      n_checks += 2;
      if (drop_count !== 16'd2) begin n_fail++; $display("FAIL crc_drop_count: got %0d want 2", drop_count); end
      if (q.size() !== 0) begin n_fail++; $display("FAIL crc_read: got %0d bytes want 0", q.size()); end
      send_frame(8'h28, 4, 8'hA0, 1'b1, -1);
      n_checks++;
      if (q.size() !== 4) begin n_fail++; $display("FAIL crc_next_len: got %0d want 4", q.size()); end
      for (int i = 0; i < 4; i++) begin
         e = {i == 3, 8'(8'hA0 + i)};
         n_checks++;
         if (q[i] !== e) begin n_fail++; $display("FAIL crc_next_byte%0d: got %h want %h", i, q[i], e); end
      end
   endtask
   task automatic test_overflow;
      int c0, d0;
      logic [8:0] e;
      c0 = n_com4; d0 = n_drop4; rd_ready4 = 1'b0;
      send_frame(8'h28, 10, 8'h10, 1'b1, -1);
      n_checks += 3;
      if (n_com4 - c0 !== 1) begin n_fail++; $display("FAIL ovf_first_commit: got %0d want 1", n_com4 - c0); end
      if (rd_valid4 !== 1'b1) begin n_fail++; $display("FAIL ovf_rd_valid: got %b want 1", rd_valid4); end
      if (rd_data4 !== 8'h10) begin n_fail++; $display("FAIL ovf_rd_data: got %h want 10", rd_data4); end
      send_frame(8'h28, 10, 8'h20, 1'b1, -1);
      n_checks += 2;
      if (n_drop4 - d0 !== 1) begin n_fail++; $display("FAIL ovf_second_drop: got %0d want 1", n_drop4 - d0); end
      if (n_com4 - c0 !== 1) begin n_fail++; $display("FAIL ovf_second_commit: got %0d want 1", n_com4 - c0); end
      q4.delete(); rd_ready4 = 1'b1;
      repeat (30) tick;
      n_checks++;
      if (q4.size() !== 10) begin n_fail++; $display("FAIL ovf_drain_len: got %0d want 10", q4.size()); end
      for (int i = 0; i < 10; i++) begin
         e = {i == 9, 8'(8'h10 + i)};
         n_checks++;
         if (q4[i] !== e) begin n_fail++; $display("FAIL ovf_drain_byte%0d: got %h want %h", i, q4[i], e); end
      end
      q4.delete();
      send_frame(8'h28, 10, 8'h30, 1'b1, -1);
      n_checks += 2;
      if (n_com4 - c0 !== 2) begin n_fail++; $display("FAIL wrap_commit: got %0d want 2", n_com4 - c0); end
      if (q4.size() !== 10) begin n_fail++; $display("FAIL wrap_len: got %0d want 10", q4.size()); end
      for (int i = 0; i < 10; i++) begin
         e = {i == 9, 8'(8'h30 + i)};
         n_checks++;
         if (q4[i] !== e) begin n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", i, q4[i], e); end
      end
   endtask
   task automatic test_toggle;
      logic prev_stall;
      logic [7:0] pd;
      logic pl;
      logic [8:0] e;
      q.delete(); rd_ready = 1'b0;
      send_frame(8'h28, 5, 8'h60, 1'b1, -1);
      for (int k = 0; k < 20 && !rd_valid; k++) tick;
      n_checks++;
      if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL toggle_wait: rd_valid got %b want 1", rd_valid); end
      prev_stall = 1'b0; pd = 8'h00; pl = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_ready = i[0];
         @(negedge clkRx);
         if (prev_stall) begin
            n_checks++;
            if (rd_data !== pd || rd_last !== pl) begin
               n_fail++; $display("FAIL toggle_stable: got %b/%h want %b/%h", rd_last, rd_data, pl, pd);
            end
         end
         prev_stall = rd_valid & ~rd_ready; pd = rd_data; pl = rd_last;
         tick;
      end
      rd_ready = 1'b1;
      repeat (5) tick;
      n_checks++;
      if (q.size() !== 5) begin n_fail++; $display("FAIL toggle_len: got %0d want 5", q.size()); end
      for (int i = 0; i < 5; i++) begin
         e = {i == 4, 8'(8'h60 + i)};
         n_checks++;
         if (q[i] !== e) begin n_fail++; $display("FAIL toggle_byte%0d: got %h want %h", i, q[i], e); end
      end
   endtask
   task automatic test_reset_mid;
      int c0;
      logic [8:0] e;
      rd_ready = 1'b0;
      send_frame(8'h28, 3, 8'h70, 1'b1, -1);
      n_checks++;
      if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", rd_valid); end
      send_frame(8'h28, 20, 8'h80, 1'b1, 45);
      n_checks += 5;
      if (s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid: got %b want 0", s_valid); end
      if (s_data !== 8'h00) begin n_fail++; $display("FAIL mid_rd_data: got %h want 00", s_data); end
      if (s_last !== 1'b0) begin n_fail++; $display("FAIL mid_rd_last: got %b want 0", s_last); end
      if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_drop_count: got %0d want 0", s_cnt); end
      if (drop_count !== 16'd1) begin n_fail++; $display("FAIL mid_tail_drop: got %0d want 1", drop_count); end
      q.delete(); rd_ready = 1'b1; c0 = n_com;
      send_frame(8'h28, 3, 8'hC0, 1'b1, -1);
      n_checks += 2;
      if (n_com - c0 !== 1) begin n_fail++; $display("FAIL mid_commit: got %0d want 1", n_com - c0); end
      if (q.size() !== 3) begin n_fail++; $display("FAIL mid_len: got %0d want 3", q.size()); end
      for (int i = 0; i < 3; i++) begin
         e = {i == 2, 8'(8'hC0 + i)};
         n_checks++;
         if (q[i] !== e) begin n_fail++; $display("FAIL mid_byte%0d: got %h want %h", i, q[i], e); end
      end
   endtask
   initial begin
      test_reset();
      test_good();
      test_bad_ip();
      test_bad_crc();
      test_overflow();
      test_toggle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
